// File: rtl/alu_issue_stage.sv
// Purpose : RV32I decode/issue register that turns an instruction and its register operands into an ALU request.
// Latency : 1 cycle from the input handshake to out_valid; sustains one instruction per cycle.
// Backpr. : in_ready = !flush && (!out_valid || out_ready); the request is held stable while out_ready is low.
// Ports   : clk/rst_n (async active-low)/flush (synchronous kill);
//           in_valid/in_ready with in_instr, in_pc, in_rs1_data, in_rs2_data;
//           out_valid/out_ready with ALUop1, ALUop2, ALUctrl, out_rd, out_rd_we, out_pc, out_illegal.
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  output logic [3:0]            ALUctrl,
  output logic [4:0]            out_rd,
  output logic                  out_rd_we,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic                  out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [DATA_WIDTH-1:0] pc;
    logic [3:0]            ctrl;
    logic [4:0]            rd;
    logic                  rd_we;
    logic                  illegal;
  } req_t;

  logic valid_q, valid_d;
  req_t req_q, req_d;
  req_t dec;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_u;
  logic                  capture;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // Immediates are sign-extended to the datapath width via signed size casts.
  assign imm_i = DATA_WIDTH'($signed(in_instr[31:20]));
  assign imm_s = DATA_WIDTH'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_u = DATA_WIDTH'($signed({in_instr[31:12], 12'b0}));

  // Decode of the incoming instruction into an ALU request.
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.rd      = in_instr[11:7];
    dec.rd_we   = 1'b1;
    dec.illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.op1  = in_rs1_data;
        dec.op2  = in_rs2_data;
        dec.ctrl = {in_instr[30], funct3};
      end
      OPC_OP_IMM: begin
        dec.op1  = in_rs1_data;
        dec.op2  = imm_i;
        // Only the shift-right group uses bit 30 (SRLI/SRAI); for the rest it is
        // immediate data and must not turn ADDI into SUB.
        dec.ctrl = (funct3 == 3'b101) ? {in_instr[30], funct3} : {1'b0, funct3};
      end
      OPC_LUI: begin
        dec.op2 = imm_u;
      end
      OPC_AUIPC: begin
        dec.op1 = in_pc;
        dec.op2 = imm_u;
      end
      OPC_LOAD: begin
        dec.op1 = in_rs1_data;
        dec.op2 = imm_i;
      end
      OPC_STORE: begin
        dec.op1   = in_rs1_data;
        dec.op2   = imm_s;
        dec.rd_we = 1'b0;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU produces the link value pc+4; targets are computed elsewhere.
        dec.op1 = in_pc;
        dec.op2 = DATA_WIDTH'(4);
      end
      OPC_BRANCH: begin
        dec.rd_we = 1'b0;
        case (funct3)
          3'b000, 3'b001: begin
            dec.op1  = in_rs1_data;
            dec.op2  = in_rs2_data;
            dec.ctrl = 4'b1000;
          end
          3'b100, 3'b101: begin
            dec.op1  = in_rs1_data;
            dec.op2  = in_rs2_data;
            dec.ctrl = 4'b0010;
          end
          3'b110, 3'b111: begin
            dec.op1  = in_rs1_data;
            dec.op2  = in_rs2_data;
            dec.ctrl = 4'b0011;
          end
          default: begin
            dec.illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec.illegal = 1'b1;
        dec.rd_we   = 1'b0;
      end
    endcase
    if (dec.rd == 5'd0) begin
      dec.rd_we = 1'b0;
    end
  end

  // Handshake and next-state logic; flush outranks both capture and hold.
  always_comb begin
    in_ready = !flush && (!valid_q || out_ready);
    capture  = in_valid && in_ready;
    valid_d  = valid_q;
    req_d    = req_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      req_d   = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign out_valid   = valid_q;
  assign ALUop1      = req_q.op1;
  assign ALUop2      = req_q.op2;
  assign ALUctrl     = req_q.ctrl;
  assign out_rd      = req_q.rd;
  assign out_rd_we   = req_q.rd_we;
  assign out_pc      = req_q.pc;
  assign out_illegal = req_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUop1;
  logic [31:0] ALUop2;
  logic [3:0]  ALUctrl;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_pc;
  logic        out_illegal;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_pc(out_pc),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] op1, input logic [31:0] op2, input logic [3:0] ctrl,
                              input logic [4:0] rd, input logic we, input logic [31:0] pc,
                              input logic ill);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.ctrl = ctrl; e.rd = rd;
    e.rd_we = we; e.pc = pc; e.illegal = ill;
    return e;
  endfunction

  // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got a request with op1=0x%08h, expected none", ALUop1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("op1",     ALUop1,              e.op1);
          chk("op2",     ALUop2,              e.op2);
          chk("ctrl",    {28'd0, ALUctrl},    {28'd0, e.ctrl});
          chk("rd",      {27'd0, out_rd},     {27'd0, e.rd});
          chk("rd_we",   {31'd0, out_rd_we},  {31'd0, e.rd_we});
          chk("pc",      out_pc,              e.pc);
          chk("illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
        end
      end
    end
  end

  // Present an instruction and wait (bounded) for it to be accepted.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input exp_t e, output int waits);
    bit done;
    in_valid = 1'b1; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: instr 0x%08h not accepted, expected acceptance within 50 cycles", ins);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 32'h0; in_rs1_data = 32'h0; in_rs2_data = 32'h0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op1",       ALUop1,             32'd0);
    chk("rst_op2",       ALUop2,             32'd0);
    chk("rst_ctrl",      {28'd0, ALUctrl},   32'd0);
    chk("rst_rd_we",     {31'd0, out_rd_we}, 32'd0);
    chk("rst_illegal",   {31'd0, out_illegal}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD x3,x1,x2
    issue(32'h002081B3, 32'h0000_0010, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 32'h10, 1'b0), w);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // ADDI x1,x0,-1 then SRAI x2,x1,4 back-to-back
    issue(32'hFFF00093, 32'h0000_0020, 32'd0, 32'd0,
          mk(32'd0, 32'hFFFF_FFFF, 4'b0000, 5'd1, 1'b1, 32'h20, 1'b0), w);
    issue(32'h4040D113, 32'h0000_0024, 32'hFFFF_FFFF, 32'd0,
          mk(32'hFFFF_FFFF, 32'h0000_0404, 4'b1101, 5'd2, 1'b1, 32'h24, 1'b0), w);
    chk("b2b_waits", w, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // SUB x0,x1,x2 under backpressure, AUIPC waiting behind it
    out_ready = 1'b0;
    issue(32'h40208033, 32'h0000_0030, 32'd10, 32'd3,
          mk(32'd10, 32'd3, 4'b1000, 5'd0, 1'b0, 32'h30, 1'b0), w);
    in_valid = 1'b1; in_instr = 32'h12345297; in_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_ctrl",     {28'd0, ALUctrl},  32'd8);
      chk("stall_op1",      ALUop1,            32'd10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(32'h12345297, 32'h0000_0100, 32'd0, 32'd0,
          mk(32'h100, 32'h1234_5000, 4'b0000, 5'd5, 1'b1, 32'h100, 1'b0), w);
    chk("release_waits", w, 32'd0);

    // BLTU x1,x2,+8 at pc 0x200
    issue(32'h0020E463, 32'h0000_0200, 32'h11, 32'h22,
          mk(32'h11, 32'h22, 4'b0011, 5'd8, 1'b0, 32'h200, 1'b0), w);
    // LUI x7,0xFFFFF
    issue(32'hFFFFF3B7, 32'h0000_0204, 32'h5, 32'h6,
          mk(32'd0, 32'hFFFF_F000, 4'b0000, 5'd7, 1'b1, 32'h204, 1'b0), w);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Flush: a stalled JAL is killed and the LUI presented alongside is refused
    out_ready = 1'b0;
    issue(32'h000000EF, 32'h0000_0300, 32'd0, 32'd0,
          mk(32'h300, 32'd4, 4'b0000, 5'd1, 1'b1, 32'h300, 1'b0), w);
    void'(sb.pop_back());
    in_valid = 1'b1; in_instr = 32'hFFFFF3B7; in_pc = 32'h304;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready",  {31'd0, in_ready},  32'd0);
    chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("flush_no_capture", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;

    // ECALL is illegal but still handshakes
    issue(32'h00000073, 32'h0000_0400, 32'h55, 32'h66,
          mk(32'd0, 32'd0, 4'b0000, 5'd0, 1'b0, 32'h400, 1'b1), w);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Async reset pulse while a JAL is stalled
    out_ready = 1'b0;
    issue(32'h000000EF, 32'h0000_0500, 32'd0, 32'd0,
          mk(32'h500, 32'd4, 4'b0000, 5'd1, 1'b1, 32'h500, 1'b0), w);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_op1",       ALUop1,            32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // JAL x1 after reset recovers normally
    issue(32'h000000EF, 32'h0000_0600, 32'd0, 32'd0,
          mk(32'h600, 32'd4, 4'b0000, 5'd1, 1'b1, 32'h600, 1'b0), w);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
